// File: rtl/tone_mixer_n.sv
// tone_mixer_n: NUM_CH phase-accumulator voices mixed through one shared saturating adder.
// Define TONE_NOISE_EN to add a per-voice 15-bit LFSR noise source (wave type 4).
module tone_mixer_n #(
   parameter int NUM_CH    = 4,
   parameter int PHASE_W   = 16,
   parameter int VOL_W     = 8,
   parameter int OUT_W     = 16,
   parameter int MIX_SHIFT = 2
) (
   input  logic             clk_in,
   input  logic             reset_in,
   input  logic             sample_tick_in,
   input  logic [15:0]      data_in,
   input  logic [7:0]       addr_in,
   input  logic             data_valid_in,
   output logic [OUT_W-1:0] data_out,
   output logic             data_valid_out,
   output logic             busy_out,
   output logic             overrun_out
);

   // state | meaning
   // IDLE  | waiting for sample_tick_in with enable set
   // ACC   | advance one voice accumulator per cycle, latch its wave bit
   // MIX   | add one voice per cycle into the saturating mix
   // DONE  | publish mix on data_out with a one-cycle valid pulse
   typedef enum logic [1:0] {IDLE, ACC, MIX, DONE} state_t;

   localparam int CH_W = $clog2(NUM_CH);
`ifdef TONE_NOISE_EN
   localparam int WT_W = 3;
`else
   localparam int WT_W = 2;
`endif
   localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
   localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] NEG_MAX = {1'b1, {(OUT_W-1){1'b0}}};

   state_t                   state;
   logic [CH_W-1:0]          ch_idx;
   logic [PHASE_W-1:0]       phase_acc  [NUM_CH];
   logic [PHASE_W-1:0]       phase_incr [NUM_CH];
   logic [VOL_W-1:0]         volume     [NUM_CH];
   logic [WT_W-1:0]          wave_type  [NUM_CH];
   logic [NUM_CH-1:0]        wave_bit;
   logic                     enable;
   logic signed [OUT_W-1:0]  mix;

   function automatic logic duty_bit(input logic [2:0] top, input logic [2:0] wt);
      case (wt)
         3'd1:    duty_bit = (top == 3'd7);
         3'd2:    duty_bit = (top >= 3'd6);
         3'd3:    duty_bit = (top >= 3'd5);
         default: duty_bit = top[2];
      endcase
   endfunction

   // Volume bits repeated MSB-first so full scale reaches the top of the positive range.
   function automatic logic [OUT_W-2:0] replicate_vol(input logic [VOL_W-1:0] vol);
      logic [OUT_W-2:0] r;
      r = '0;
      for (int j = 0; j < OUT_W-1; j++)
         r[OUT_W-2-j] = vol[VOL_W-1-(j % VOL_W)];
      return r;
   endfunction

   logic [PHASE_W:0]   acc_sum;
   logic [PHASE_W-1:0] acc_next;
   logic [2:0]         wt_cur;
   logic               wave_next;

   assign acc_sum  = {1'b0, phase_acc[ch_idx]} + {1'b0, phase_incr[ch_idx]};
   assign acc_next = acc_sum[PHASE_W-1:0];
   assign wt_cur   = 3'(wave_type[ch_idx]);

`ifdef TONE_NOISE_EN
   logic [14:0] lfsr [NUM_CH];
   logic [14:0] lfsr_next;
   assign lfsr_next = acc_sum[PHASE_W] ? {lfsr[ch_idx][13:0], lfsr[ch_idx][14] ^ lfsr[ch_idx][13]}
                                       : lfsr[ch_idx];
   assign wave_next = (wt_cur == 3'd4) ? lfsr_next[0]
                                       : duty_bit(acc_next[PHASE_W-1 -: 3], wt_cur);
`else
   assign wave_next = duty_bit(acc_next[PHASE_W-1 -: 3], wt_cur);
`endif

   logic signed [OUT_W-1:0] amp;
   logic signed [OUT_W-1:0] voice_v;
   logic signed [OUT_W-1:0] voice_s;
   logic signed [OUT_W:0]   mix_sum;
   logic [OUT_W-1:0]        mix_sat;

   assign amp     = {1'b0, replicate_vol(volume[ch_idx])};
   assign voice_v = wave_bit[ch_idx] ? amp : ~amp;
   assign voice_s = voice_v >>> MIX_SHIFT;
   assign mix_sum = {mix[OUT_W-1], mix} + {voice_s[OUT_W-1], voice_s};
   assign mix_sat = (mix_sum[OUT_W] != mix_sum[OUT_W-1]) ? (mix_sum[OUT_W] ? NEG_MAX : POS_MAX)
                                                         : mix_sum[OUT_W-1:0];

   logic                  wr_ch_ok;
   logic [CH_W-1:0]       wr_ch;
   logic [PHASE_W+15:0]   incr_ext;
   logic [VOL_W+15:0]     vol_ext;
   logic                  unused_bits;

   assign wr_ch_ok    = (addr_in[5:4] == 2'b00) && ({1'b0, addr_in[3:0]} < 5'(NUM_CH));
   assign wr_ch       = addr_in[CH_W-1:0];
   assign incr_ext    = {{PHASE_W{1'b0}}, data_in};
   assign vol_ext     = {{VOL_W{1'b0}}, data_in};
   assign unused_bits = ^{data_in, incr_ext, vol_ext, acc_sum[PHASE_W]};

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state          <= IDLE;
         ch_idx         <= '0;
         data_out       <= '0;
         data_valid_out <= 1'b0;
         busy_out       <= 1'b0;
         overrun_out    <= 1'b0;
         enable         <= 1'b0;
         mix            <= '0;
         wave_bit       <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            phase_acc[i]  <= '0;
            phase_incr[i] <= '0;
            volume[i]     <= '0;
            wave_type[i]  <= '0;
`ifdef TONE_NOISE_EN
            lfsr[i]       <= 15'h0001;
`endif
         end
      end else begin
         data_valid_out <= 1'b0;
         case (state)
            IDLE: begin
               if (sample_tick_in && enable) begin
                  state    <= ACC;
                  ch_idx   <= '0;
                  busy_out <= 1'b1;
               end
            end
            ACC: begin
               phase_acc[ch_idx] <= acc_next;
               wave_bit[ch_idx]  <= wave_next;
`ifdef TONE_NOISE_EN
               lfsr[ch_idx]      <= lfsr_next;
`endif
               if (ch_idx == LAST_CH) begin
                  state  <= MIX;
                  ch_idx <= '0;
                  mix    <= '0;
               end else begin
                  ch_idx <= ch_idx + 1'b1;
               end
            end
            MIX: begin
               mix <= mix_sat;
               if (ch_idx == LAST_CH) state <= DONE;
               else                   ch_idx <= ch_idx + 1'b1;
            end
            DONE: begin
               data_out       <= mix;
               data_valid_out <= 1'b1;
               busy_out       <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (sample_tick_in && state != IDLE) overrun_out <= 1'b1;

         // Host writes come last so a phase clear beats the ACC update of the same cycle.
         if (data_valid_in) begin
            case (addr_in[7:6])
               2'b00: if (wr_ch_ok) phase_incr[wr_ch] <= incr_ext[PHASE_W-1:0];
               2'b01: if (wr_ch_ok) volume[wr_ch]     <= vol_ext[VOL_W-1:0];
               2'b10: if (wr_ch_ok) wave_type[wr_ch]  <= data_in[WT_W-1:0];
               default: begin
                  if (addr_in == 8'hC0) begin
                     enable <= data_in[0];
                     if (data_in[1]) overrun_out <= 1'b0;
                  end
                  if (addr_in == 8'hC1) begin
                     for (int i = 0; i < NUM_CH; i++) phase_acc[i] <= '0;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tone_mixer_n.sv
// Bench for tone_mixer_n: default instance plus a MIX_SHIFT=0 instance, scoreboarded
// against a behavioural mixing model.
module tb_tone_mixer_n;

   typedef struct {
      logic [15:0] d;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick = 1'b0;
   logic        dv = 1'b0;
   logic [15:0] din = '0;
   logic [7:0]  addr = '0;
   logic [15:0] dout0, dout1;
   logic        vld0, vld1, busy0, busy1, ovr0, ovr1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;

   logic [15:0] m_phase [4];
   int          m_incr  [4];
   int          m_vol   [4];
   int          m_wave  [4];
   bit          m_en;

   tone_mixer_n dut (
      .clk_in(clk), .reset_in(rst), .sample_tick_in(tick), .data_in(din), .addr_in(addr),
      .data_valid_in(dv), .data_out(dout0), .data_valid_out(vld0), .busy_out(busy0),
      .overrun_out(ovr0)
   );

   tone_mixer_n #(.MIX_SHIFT(0)) dut_s0 (
      .clk_in(clk), .reset_in(rst), .sample_tick_in(tick), .data_in(din), .addr_in(addr),
      .data_valid_in(dv), .data_out(dout1), .data_valid_out(vld1), .busy_out(busy1),
      .overrun_out(ovr1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_phase[i] = '0;
         m_incr[i]  = 0;
         m_vol[i]   = 0;
         m_wave[i]  = 0;
      end
   endtask

   function automatic logic [15:0] model_mix(input int shift);
      int         m, amp, v;
      logic [2:0] top;
      bit         b;
      m = 0;
      for (int i = 0; i < 4; i++) begin
         top = m_phase[i][15:13];
         case (m_wave[i])
            0:       b = top[2];
            1:       b = (top == 3'd7);
            2:       b = (top >= 3'd6);
            default: b = (top >= 3'd5);
         endcase
         amp = (m_vol[i] << 7) | (m_vol[i] >> 1);
         v   = b ? amp : -amp - 1;
         v   = v >>> shift;
         m   = m + v;
         if (m > 32767)  m = 32767;
         if (m < -32768) m = -32768;
      end
      return 16'(m);
   endfunction

   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      @(posedge clk); #1;
      addr = a; din = d; dv = 1'b1;
      @(posedge clk); #1;
      dv = 1'b0;
      if (a[5:4] == 2'b00 && a[3:2] == 2'b00) begin
         case (a[7:6])
            2'b00: m_incr[a[1:0]] = int'(d);
            2'b01: m_vol[a[1:0]]  = int'(d[7:0]);
            2'b10: m_wave[a[1:0]] = int'(d[1:0]);
            default: ;
         endcase
      end
      if (a == 8'hC0) m_en = d[0];
      if (a == 8'hC1) for (int i = 0; i < 4; i++) m_phase[i] = '0;
   endtask

   task automatic do_tick(input bit frame);
      exp_t e;
      @(posedge clk); #1;
      tick = 1'b1;
      if (frame) begin
         for (int i = 0; i < 4; i++) m_phase[i] = m_phase[i] + 16'(m_incr[i]);
         e.cyc = cyc + 10;
         e.d   = model_mix(2);
         q0.push_back(e);
         e.d   = model_mix(0);
         q1.push_back(e);
      end
      @(posedge clk); #1;
      tick = 1'b0;
   endtask

   always @(negedge clk) begin
      if (vld0 === 1'b1) begin
         chk("valid0_expected", q0.size() > 0, 1);
         if (q0.size() > 0) begin
            e0 = q0.pop_front();
            chk("sample0", dout0, e0.d);
            chk("latency0", cyc, e0.cyc);
         end
      end
      if (vld1 === 1'b1) begin
         chk("valid1_expected", q1.size() > 0, 1);
         if (q1.size() > 0) begin
            e1 = q1.pop_front();
            chk("sample1", dout1, e1.d);
            chk("latency1", cyc, e1.cyc);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("in_reset_busy", busy0, 0);
      chk("in_reset_dout", dout0, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("reset_dout", dout0, 0);
      chk("reset_valid", vld0, 0);
      chk("reset_busy", busy0, 0);
      chk("reset_overrun", ovr0, 0);
      chk("reset_dout_s0", dout1, 0);

      do_tick(m_en);
      chk("disabled_busy", busy0, 0);
      repeat (14) @(posedge clk); #1;
      chk("disabled_dout", dout0, 0);
      chk("disabled_overrun", ovr0, 0);

      wr(8'h00, 16'h2000);
      wr(8'h40, 16'h00FF);
      wr(8'h80, 16'h0000);
      wr(8'hC0, 16'h0001);
      for (int t = 1; t <= 4; t++) begin
         do_tick(1'b1);
         chk("sv_busy", busy0, 1);
         repeat (14) @(posedge clk); #1;
         if (t == 1) chk("sv_tick1", dout0, 16'hDFFD);
         if (t == 4) chk("sv_tick4", dout0, 16'h1FFC);
      end
      chk("sv_idle", busy0, 0);

      wr(8'h80, 16'h0003);
      wr(8'h01, 16'h3000); wr(8'h41, 16'h0080); wr(8'h81, 16'h0001);
      wr(8'h02, 16'hE000); wr(8'h42, 16'h0040); wr(8'h82, 16'h0002);
      wr(8'h03, 16'h0700); wr(8'h43, 16'h0011); wr(8'h83, 16'h0000);
      wr(8'h44, 16'h00AA);
      wr(8'h07, 16'h1234);
      for (int t = 0; t < 4; t++) begin
         do_tick(1'b1);
         repeat (14) @(posedge clk);
      end

      wr(8'hC1, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         wr(8'h00 + 8'(i), 16'h8000);
         wr(8'h40 + 8'(i), 16'h00FF);
         wr(8'h80 + 8'(i), 16'h0000);
      end
      do_tick(1'b1);
      repeat (14) @(posedge clk); #1;
      chk("sat_pos", dout1, 16'h7FFF);
      chk("nosat_pos", dout0, 16'h7FFC);
      do_tick(1'b1);
      repeat (14) @(posedge clk); #1;
      chk("sat_neg", dout1, 16'h8000);

      do_tick(1'b1);
      repeat (2) @(posedge clk);
      do_tick(1'b0);
      repeat (14) @(posedge clk); #1;
      chk("overrun_set", ovr0, 1);
      chk("overrun_set_s0", ovr1, 1);
      wr(8'hC0, 16'h0003);
      chk("overrun_clear", ovr0, 0);
      do_tick(1'b1);
      repeat (14) @(posedge clk);

      do_tick(1'b0);
      repeat (6) @(posedge clk); #1;
      chk("mid_busy", busy0, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy0, 0);
      chk("mid_rst_dout", dout0, 0);
      chk("mid_rst_valid", vld0, 0);
      chk("mid_rst_dout_s0", dout1, 0);
      #2;
      rst = 1'b0;
      model_reset();
      repeat (20) @(posedge clk); #1;
      chk("post_rst_busy", busy0, 0);
      chk("post_rst_dout", dout0, 0);

      wr(8'h00, 16'h1000);
      wr(8'h40, 16'h003C);
      wr(8'hC0, 16'h0001);
      do_tick(1'b1);
      repeat (16) @(posedge clk); #1;

      chk("queue0_drained", q0.size(), 0);
      chk("queue1_drained", q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
